med_schedule_engine: RTL
========================

// Module: med_schedule_engine
// PURPOSE
//   Multi-slot medication scheduler: holds NUM_SLOTS programmable dose times, runs a
//   prescaled wrapping time base, raises an alarm for each due slot, waits for a patient
//   acknowledge and records every dose event in a log FIFO. Sits between pin-mapping
//   top level (program/ack/readout) and display/LCD driver (consumes alarm + log).
// PARAMETERS
//   NUM_SLOTS   8    number of dose slots (power of 2, 2..16)
//   TIME_W      8    width of time base and slot times; time wraps modulo 2**TIME_W
//   PRESCALE    1000 clk cycles per time tick (>=1; 1 = tick every enabled cycle)
//   LOG_DEPTH   16   log FIFO entries (power of 2)
//   MISS_TICKS  4    ticks before unacknowledged alarm is logged missed (MED_MISS_TIMEOUT_EN)
// PORTS
//   clk        in   1          system clock
//   rst_n      in   1          async active-low reset
//   ena        in   1          time base advances only when high; FSM/FIFO always run
//   prog_we    in   1          write slot table entry this cycle
//   prog_slot  in   SLOT_W     slot index, SLOT_W = clog2(NUM_SLOTS)
//   prog_time  in   TIME_W     dose time for slot
//   prog_en    in   1          slot enable bit written alongside time
//   ack        in   1          patient acknowledge of current alarm
//   alarm      out  1          alarm active (registered)
//   alarm_slot out  SLOT_W     slot being alarmed, valid while alarm=1
//   time_now   out  TIME_W     current time base value
//   log_rd     in   1          pop log head (ignored when log_valid=0)
//   log_valid  out  1          log FIFO non-empty
//   log_data   out  2+SLOT_W+TIME_W  head entry {taken,missed,slot,time}
//   log_ovf    out  1          sticky: a log push was dropped because FIFO full
// BEHAVIOUR
//   Reset: time_now=0, prescaler=0, all slots disabled time 0, pending=0, FSM IDLE,
//     alarm=0, alarm_slot=0, FIFO empty, log_valid=0, log_data=0, log_ovf=0.
//   Time base: prescaler counts 0..PRESCALE-1 while ena; tick at terminal count;
//     on tick time_now <= time_now+1 (wrap to 0). ena low freezes prescaler + time.
//   Due: on tick edge, pending[i] set for every enabled slot with slot_time==time_now+1.
//   Programming: prog_we writes slot at edge, effective next cycle; clears pending[slot];
//     if slot is alarmed, FSM returns IDLE, alarm drops next cycle, nothing logged.
//   FSM IDLE: if pending!=0 latch lowest set index to alarm_slot, -> ALERT (alarm=1).
//     Tick-to-alarm latency: alarm high 2 clk after the tick edge.
//   FSM ALERT: ack=1 -> push {1,0,slot,time_now}, clear pending[slot], -> IDLE.
//     ack in IDLE ignored. Tick during ALERT still sets other pending bits.
//     Same slot re-due while pending: stays single pending, no duplicate.
//   FIFO: push+pop same cycle always legal (also when full: both happen). Push when
//     full without pop: dropped, log_ovf<=1 until reset. log_data = head, first-word
//     fall-through, updated cycle after pop.
// CONFIGURATION
//   MED_MISS_TIMEOUT_EN defined: ALERT counts ticks; at MISS_TICKS ticks without ack
//     pushes {0,1,slot,time_now}, clears pending[slot], -> IDLE. ack on the timeout
//     edge wins (logged taken).
//   Not defined: ALERT holds until ack or reprogram; no missed entries ever logged.
// STRUCTURE
//   med_pkg: log entry struct, FSM state enum (IDLE, ALERT), SLOT_W helper function.
//   Sub-module med_log_fifo (parametric width/depth, ovf flag); rest in this module.
// TESTING
//   Prog slot2 t=5 en, PRESCALE=1 -> tick to time 5; alarm=1 slot2 2 clk later; ack -> log {1,0,2,5}.
//   Slots 1,3 both t=7 -> alarm slot1, ack, next cycle IDLE, then alarm slot3; log order 1 then 3.
//   Time 255 tick -> time_now=0; slot t=0 fires after wrap; ena=0 holds time_now.
//   Fill 16 log entries, 17th ack -> dropped, log_ovf=1; pop+push same cycle when full -> count stays 16.
//   Reprogram alarmed slot mid-ALERT -> alarm drops, no log; rst_n low mid-ALERT -> all reset values.
//   MISS_TIMEOUT_EN, MISS_TICKS=4: no ack for 4 ticks -> log {0,1,slot,t}; ack on 4th tick edge -> taken.

Source files
------------

// File: rtl/med_pkg.sv
// Shared types for the medication scheduler: FSM states, log entry layout
// and slot-index width helper.
package med_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ALERT = 1'b1
  } state_e;

  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_SLOTS = 8;
  localparam int DEF_TIME_W    = 8;
  localparam int DEF_SLOT_W    = slot_w(DEF_NUM_SLOTS);

  // log_data layout for the default geometry
  typedef struct packed {
    logic                  taken;
    logic                  missed;
    logic [DEF_SLOT_W-1:0] slot;
    logic [DEF_TIME_W-1:0] tm;
  } log_entry_t;

endpackage

// File: rtl/med_schedule_engine_if.sv
// Host-side bundle of the scheduler: programming, acknowledge,
// alarm status and log readout.
interface med_schedule_engine_if #(
  parameter int NUM_SLOTS = 8,
  parameter int TIME_W    = 8
);
  import med_pkg::*;

  localparam int SLOT_W = slot_w(NUM_SLOTS);
  localparam int LOG_W  = 2 + SLOT_W + TIME_W;

  logic              ena;
  logic              prog_we;
  logic [SLOT_W-1:0] prog_slot;
  logic [TIME_W-1:0] prog_time;
  logic              prog_en;
  logic              ack;
  logic              alarm;
  logic [SLOT_W-1:0] alarm_slot;
  logic [TIME_W-1:0] time_now;
  logic              log_rd;
  logic              log_valid;
  logic [LOG_W-1:0]  log_data;
  logic              log_ovf;

  modport master (
    output ena, prog_we, prog_slot, prog_time,
    output prog_en, ack, log_rd,
    input  alarm, alarm_slot, time_now,
    input  log_valid, log_data, log_ovf
  );

  modport slave (
    input  ena, prog_we, prog_slot, prog_time,
    input  prog_en, ack, log_rd,
    output alarm, alarm_slot, time_now,
    output log_valid, log_data, log_ovf
  );

endinterface

// File: rtl/med_log_fifo.sv
// First-word fall-through dose log FIFO with sticky overflow flag;
// a push into a full FIFO is kept when a pop happens the same cycle.
module med_log_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         ovf_q, ovf_d;
  logic         empty, full;
  logic         push_ok, pop_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    if (push_i && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/med_schedule_engine.sv
// Multi-slot medication scheduler: prescaled time base, due detection,
// alarm/ack FSM and dose log. MED_MISS_TIMEOUT_EN adds missed-dose logging.
module med_schedule_engine
  import med_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int TIME_W     = 8,
  parameter int PRESCALE   = 1000,
  parameter int LOG_DEPTH  = 16,
  parameter int MISS_TICKS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  med_schedule_engine_if.slave bus
);

  localparam int SLOT_W = slot_w(NUM_SLOTS);
  localparam int LOG_W  = 2 + SLOT_W + TIME_W;
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int MC_W   = $clog2(MISS_TICKS + 1);

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [MC_W-1:0]  MISS_MAX = MC_W'(MISS_TICKS - 1);

`ifdef MED_MISS_TIMEOUT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [TIME_W-1:0]    time_nxt;
  logic [TIME_W-1:0]    stime_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] en_q;
  logic [NUM_SLOTS-1:0] pend_q, pend_d;
  logic [NUM_SLOTS-1:0] due, prog_clr, done_clr, avail;
  logic [SLOT_W-1:0]    first;
  logic [MC_W-1:0]      miss_q, miss_d;

  state_e               state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic                 alarm_q, alarm_d;

  logic                 tick, prog_hit, take, miss;
  logic                 push;
  logic [LOG_W-1:0]     push_data;

  assign tick     = bus.ena && (pre_q == PRE_MAX);
  assign time_nxt = time_q + 1'b1;

  always_comb begin
    pre_d  = pre_q;
    time_d = time_q;
    if (bus.ena) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
    if (tick) time_d = time_nxt;
  end

  always_comb begin
    due = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      due[i] = tick && en_q[i] && (stime_q[i] == time_nxt);
    end
  end

  always_comb begin
    prog_clr = '0;
    if (bus.prog_we) prog_clr[bus.prog_slot] = 1'b1;
  end

  assign prog_hit = bus.prog_we && (state_q == ALERT) &&
                    (bus.prog_slot == slot_q);
  assign take     = (state_q == ALERT) && bus.ack && !prog_hit;
  assign miss     = MISS_EN && (state_q == ALERT) && tick &&
                    (miss_q == MISS_MAX) && !bus.ack && !prog_hit;

  always_comb begin
    done_clr = '0;
    if (take || miss) done_clr[slot_q] = 1'b1;
  end

  // a slot being reprogrammed this cycle must not be picked up
  assign avail  = pend_q & ~prog_clr;
  assign pend_d = (pend_q | due) & ~prog_clr & ~done_clr;

  always_comb begin
    first = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (avail[i]) first = SLOT_W'(i);
    end
  end

  always_comb begin
    miss_d = '0;
    if (state_q == ALERT) begin
      miss_d = tick ? miss_q + 1'b1 : miss_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      time_q <= '0;
      pend_q <= '0;
      miss_q <= '0;
    end else begin
      pre_q  <= pre_d;
      time_q <= time_d;
      pend_q <= pend_d;
      miss_q <= miss_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) stime_q[i] <= '0;
      en_q <= '0;
    end else if (bus.prog_we) begin
      stime_q[bus.prog_slot] <= bus.prog_time;
      en_q[bus.prog_slot]    <= bus.prog_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: begin
        if (|avail) begin
          state_d = ALERT;
          slot_d  = first;
        end
      end
      ALERT: begin
        if (prog_hit || take || miss) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // alarm rises one cycle after ALERT is entered and falls on exit
  always_comb begin
    alarm_d   = (state_q == ALERT) && (state_d == ALERT);
    push      = take || miss;
    push_data = {take, miss, slot_q, time_q};
  end

  med_log_fifo #(
    .W     (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (bus.log_rd),
    .valid_o (bus.log_valid),
    .data_o  (bus.log_data),
    .ovf_o   (bus.log_ovf)
  );

  assign bus.alarm      = alarm_q;
  assign bus.alarm_slot = slot_q;
  assign bus.time_now   = time_q;

endmodule
